top_led_ctrl: RTL and testbench

//  Board-level top: one push-button (btn1) steps a 3-LED display through four modes
//  (off, blink, binary count, rotate). Contains synchronizer, debouncer, mode FSM and

---
 rtl/top_led_ctrl_pkg.sv | 36 +++
 rtl/top_led_ctrl_if.sv | 8 +
 rtl/top_led_ctrl_btn_debounce.sv | 59 +++++
 rtl/top_led_ctrl.sv | 86 ++++++++
 tb/tb_top_led_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/top_led_ctrl_pkg.sv
// Shared types and constants for the push-button LED mode controller.
package top_led_ctrl_pkg;

  localparam int unsigned LED_W = 3;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_COUNT = 2'd2,
    MODE_SHIFT = 2'd3
  } mode_e;

  localparam logic [LED_W-1:0] PAT_OFF   = 3'b000;
  localparam logic [LED_W-1:0] PAT_BLINK = 3'b000;
  localparam logic [LED_W-1:0] PAT_COUNT = 3'b000;
  localparam logic [LED_W-1:0] PAT_SHIFT = 3'b001;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_OFF:   return MODE_BLINK;
      MODE_BLINK: return MODE_COUNT;
      MODE_COUNT: return MODE_SHIFT;
      default:    return MODE_OFF;
    endcase
  endfunction

  function automatic logic [LED_W-1:0] init_pat(input mode_e m);
    case (m)
      MODE_BLINK: return PAT_BLINK;
      MODE_COUNT: return PAT_COUNT;
      MODE_SHIFT: return PAT_SHIFT;
      default:    return PAT_OFF;
    endcase
  endfunction

endpackage

// File: rtl/top_led_ctrl_if.sv
// Board-side signals of the LED controller: raw button in, LED drive out.
interface top_led_ctrl_if;
  logic                                btn1;
  logic [top_led_ctrl_pkg::LED_W-1:0] led;

  modport master (output btn1, input led);
  modport slave  (input btn1, output led);
endinterface

// File: rtl/top_led_ctrl_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, level debouncer and registered press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync0, sync1;
  logic [1:0]       settle;
  logic [CNT_W-1:0] cnt;
  logic             stable, stable_d, armed;

  // settle marks when sync1 reflects the real pin after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      settle <= 2'b00;
    end else begin
      sync0  <= btn;
      sync1  <= sync0;
      settle <= {settle[0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync1 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      stable <= sync1;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // armed only once the button has been seen released, so a hold across reset is no press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d <= 1'b0;
      armed    <= 1'b0;
      press    <= 1'b0;
    end else begin
      stable_d <= stable;
      if (settle[1] && !sync1 && !stable) armed <= 1'b1;
      press <= armed && stable && !stable_d;
    end
  end

endmodule

// File: rtl/top_led_ctrl.sv
// Board top: button steps LEDs through OFF/BLINK/COUNT/SHIFT.
// Define TOP_LED_CTRL_HEARTBEAT_EN to turn led[2] into a heartbeat and narrow patterns to led[1:0].
module top_led_ctrl
  import top_led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned BLINK_DIV       = 4096
) (
  input  logic           clk,
  input  logic           rst,
  top_led_ctrl_if.slave  io
);

  localparam int unsigned PRE_W = $clog2(BLINK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(BLINK_DIV - 1);
`ifdef TOP_LED_CTRL_HEARTBEAT_EN
  localparam int unsigned PAT_W = LED_W - 1;
`else
  localparam int unsigned PAT_W = LED_W;
`endif

  logic             press;
  logic             tick_c;
  logic [PRE_W-1:0] presc;
  mode_e            mode_q, mode_d;
  logic [PAT_W-1:0] pat_q, pat_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (io.btn1),
    .press (press)
  );

  assign tick_c = (presc == PRE_MAX);

  // step prescaler; a press restarts the period so the new mode shows a full first step
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  presc <= '0;
    else if (press || tick_c) presc <= '0;
    else                      presc <= presc + PRE_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_OFF;
      pat_q  <= '0;
    end else begin
      mode_q <= mode_d;
      pat_q  <= pat_d;
    end
  end

  // press takes priority over a coincident tick
  always_comb begin
    mode_d = mode_q;
    pat_d  = pat_q;
    if (press) begin
      mode_d = next_mode(mode_q);
      pat_d  = PAT_W'(init_pat(next_mode(mode_q)));
    end else if (tick_c) begin
      case (mode_q)
        MODE_BLINK: pat_d = ~pat_q;
        MODE_COUNT: pat_d = pat_q + PAT_W'(1);
        MODE_SHIFT: pat_d = {pat_q[PAT_W-2:0], pat_q[PAT_W-1]};
        default:    pat_d = pat_q;
      endcase
    end
  end

`ifdef TOP_LED_CTRL_HEARTBEAT_EN
  logic hb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         hb_q <= 1'b0;
    else if (tick_c) hb_q <= ~hb_q;
  end

  assign io.led = {hb_q, pat_q};
`else
  assign io.led = pat_q;
`endif

endmodule

// File: tb/tb_top_led_ctrl.sv
// Directed bench for top_led_ctrl with DEBOUNCE_CYCLES=8, BLINK_DIV=16.
module tb_top_led_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

`ifdef TOP_LED_CTRL_HEARTBEAT_EN
  localparam logic [2:0] MASK = 3'b011;
`else
  localparam logic [2:0] MASK = 3'b111;
`endif

  top_led_ctrl_if bus ();

  top_led_ctrl #(
    .DEBOUNCE_CYCLES(8),
    .BLINK_DIV      (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if ((got & MASK) !== (exp & MASK)) begin
      failures++;
      $display("FAIL %s: led=%b expected=%b", tag, got & MASK, exp & MASK);
    end
  endtask

  // advance n rising edges and settle 1 time unit past the last one
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // drive btn1 high; returns on the edge where the new mode is loaded (N+DEBOUNCE+3)
  task automatic press_btn();
    bus.btn1 = 1'b1;
    cyc(12);
  endtask

  logic [2:0] sh_exp [4];
  logic [2:0] seen;
  logic       hb0;

  initial begin
`ifdef TOP_LED_CTRL_HEARTBEAT_EN
    sh_exp[0] = 3'b001; sh_exp[1] = 3'b010; sh_exp[2] = 3'b001; sh_exp[3] = 3'b010;
`else
    sh_exp[0] = 3'b001; sh_exp[1] = 3'b010; sh_exp[2] = 3'b100; sh_exp[3] = 3'b001;
`endif
    rst      = 1'b1;
    bus.btn1 = 1'b0;
    #1;
    check("reset_led", bus.led, 3'b000);
    cyc(3);
    rst = 1'b0;

    // idle: no press ever
    seen = 3'b000;
    for (int i = 0; i < 2000; i++) begin
      cyc(1);
      seen = seen | bus.led;
    end
    check("idle_off", seen, 3'b000);

    // short glitch is ignored
    bus.btn1 = 1'b1;
    cyc(5);
    bus.btn1 = 1'b0;
    cyc(30);
    check("glitch_ignored", bus.led, 3'b000);

    // BLINK
    press_btn();
    check("blink_load", bus.led, 3'b000);
    cyc(8);
    bus.btn1 = 1'b0;
    cyc(7);
    check("blink_before_tick", bus.led, 3'b000);
    cyc(1);
    check("blink_on", bus.led, 3'b111);
    cyc(15);
    check("blink_hold", bus.led, 3'b111);
    cyc(1);
    check("blink_off", bus.led, 3'b000);

    // COUNT with wrap
    press_btn();
    check("count_load", bus.led, 3'b000);
    cyc(8);
    bus.btn1 = 1'b0;
    cyc(8);
    check("count_1", bus.led, 3'b001);
    for (int k = 2; k <= 8; k++) begin
      hb0 = bus.led[2];
      cyc(16);
      check($sformatf("count_%0d", k), bus.led, 3'(k));
`ifdef TOP_LED_CTRL_HEARTBEAT_EN
      check("hb_toggle", {2'b00, bus.led[2]}, {2'b00, ~hb0});
`endif
    end

    // SHIFT
    press_btn();
    check("shift_load", bus.led, sh_exp[0]);
    cyc(8);
    bus.btn1 = 1'b0;
    cyc(8);
    check("shift_1", bus.led, sh_exp[1]);
    for (int k = 2; k < 4; k++) begin
      cyc(16);
      check($sformatf("shift_%0d", k), bus.led, sh_exp[k]);
    end

    // back to OFF
    press_btn();
    check("off_load", bus.led, 3'b000);
    cyc(8);
    bus.btn1 = 1'b0;
    seen = 3'b000;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      seen = seen | bus.led;
    end
    check("off_hold", seen, 3'b000);

    // reach COUNT=101 then reset asynchronously between edges
    press_btn();
    check("blink_load2", bus.led, 3'b000);
    cyc(8);
    bus.btn1 = 1'b0;
    cyc(24);
    press_btn();
    check("count_load2", bus.led, 3'b000);
    cyc(8);
    bus.btn1 = 1'b0;
    cyc(8);
    for (int k = 2; k <= 5; k++) cyc(16);
    check("count_101", bus.led, 3'b101);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", bus.led, 3'b000);

    // button held through reset release is not a press
    bus.btn1 = 1'b1;
    cyc(2);
    rst = 1'b0;
    seen = 3'b000;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      seen = seen | bus.led;
    end
    check("held_thru_rst", seen, 3'b000);
    bus.btn1 = 1'b0;
    cyc(20);
    press_btn();
    check("blink_after_rst", bus.led, 3'b000);
    cyc(8);
    bus.btn1 = 1'b0;
    cyc(8);
    check("blink_on_after_rst", bus.led, 3'b111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
